// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side uses the master modport; the controller uses slave.
interface pipe_hazard_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_D;
    logic [4:0] a3_E;
    logic       we_E;
    logic [1:0] tnew_E;
    logic [4:0] a3_M;
    logic       we_M;
    logic [1:0] tnew_M;
    logic [1:0] md_op_E;
    logic       stall;
    logic       pc_en;
    logic       d_en;
    logic       e_clr;
    logic       md_start;
    logic       md_busy;
    logic       md_done;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        output a3_E, we_E, tnew_E, a3_M, we_M, tnew_M, md_op_E,
        input  stall, pc_en, d_en, e_clr, md_start, md_busy, md_done
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        input  a3_E, we_E, tnew_E, a3_M, we_M, tnew_M, md_op_E,
        output stall, pc_en, d_en, e_clr, md_start, md_busy, md_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: Tuse/Tnew RAW detection plus IDLE/BUSY sequencing of the mult/div unit.
// Optional HAZARD_PERF_EN adds a saturating 32-bit stall-cycle counter on port stall_cnt.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic          clk,
    input  logic          reset,
`ifdef HAZARD_PERF_EN
    output logic [31:0]   stall_cnt,
`endif
    pipe_hazard_if.slave  hz
);

    localparam int unsigned PERF_W = 32;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             md_busy_q;
    logic             md_done_q;

    logic             hz_rs;
    logic             hz_rt;
    logic             hz_md;
    logic             md_op_valid;
    logic             md_start_c;
    logic             stall_c;
    logic [CNT_W-1:0] md_load;

    // RAW hazard: producer in E/M writes the register and its result arrives later than D needs it
    always_comb begin
        hz_rs = (hz.rs_D != 5'd0) &&
                ((hz.we_E && (hz.a3_E == hz.rs_D) && (hz.tnew_E > hz.tuse_rs_D)) ||
                 (hz.we_M && (hz.a3_M == hz.rs_D) && (hz.tnew_M > hz.tuse_rs_D)));
        hz_rt = (hz.rt_D != 5'd0) &&
                ((hz.we_E && (hz.a3_E == hz.rt_D) && (hz.tnew_E > hz.tuse_rt_D)) ||
                 (hz.we_M && (hz.a3_M == hz.rt_D) && (hz.tnew_M > hz.tuse_rt_D)));
    end

    always_comb begin
        md_op_valid = (hz.md_op_E == 2'b01) || (hz.md_op_E == 2'b10);
        md_start_c  = (state_q == IDLE) && md_op_valid && !reset;
        md_load     = (hz.md_op_E == 2'b01) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        hz_md       = hz.md_D && (md_busy_q || md_start_c);
        stall_c     = !reset && (hz_rs || hz_rt || hz_md);
    end

    assign hz.stall    = stall_c;
    assign hz.pc_en    = !stall_c;
    assign hz.d_en     = !stall_c;
    assign hz.e_clr    = stall_c || reset;
    assign hz.md_start = md_start_c;
    assign hz.md_busy  = md_busy_q;
    assign hz.md_done  = md_done_q;

    // MD sequencer; md_done is pre-computed so it is high exactly while cnt_q == 1
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    md_done_q <= 1'b0;
                    if (md_start_c) begin
                        state_q   <= BUSY;
                        cnt_q     <= md_load;
                        md_busy_q <= 1'b1;
                        md_done_q <= (md_load == CNT_W'(1));
                    end
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        md_busy_q <= 1'b0;
                        md_done_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q - CNT_W'(1);
                        md_done_q <= (cnt_q == CNT_W'(2));
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    md_busy_q <= 1'b0;
                    md_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipe_hazard_if hz_if ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    pipe_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
`ifdef HAZARD_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .hz        (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // stall, pc_en, d_en, e_clr in one shot
    task automatic check_hz(input string tag, input logic st, input logic clr);
        check({tag, ".stall"}, 32'(hz_if.stall), 32'(st));
        check({tag, ".pc_en"}, 32'(hz_if.pc_en), 32'(!st));
        check({tag, ".d_en"},  32'(hz_if.d_en),  32'(!st));
        check({tag, ".e_clr"}, 32'(hz_if.e_clr), 32'(clr));
    endtask

    task automatic check_md(input string tag, input logic st, input logic bz, input logic dn);
        check({tag, ".md_start"}, 32'(hz_if.md_start), 32'(st));
        check({tag, ".md_busy"},  32'(hz_if.md_busy),  32'(bz));
        check({tag, ".md_done"},  32'(hz_if.md_done),  32'(dn));
    endtask

    task automatic clear_inputs();
        hz_if.rs_D      = 5'd0;
        hz_if.rt_D      = 5'd0;
        hz_if.tuse_rs_D = 2'd3;
        hz_if.tuse_rt_D = 2'd3;
        hz_if.md_D      = 1'b0;
        hz_if.a3_E      = 5'd0;
        hz_if.we_E      = 1'b0;
        hz_if.tnew_E    = 2'd0;
        hz_if.a3_M      = 5'd0;
        hz_if.we_M      = 1'b0;
        hz_if.tnew_M    = 2'd0;
        hz_if.md_op_E   = 2'b00;
    endtask

    task automatic load_use();
        hz_if.we_E      = 1'b1;
        hz_if.a3_E      = 5'd8;
        hz_if.tnew_E    = 2'd2;
        hz_if.rs_D      = 5'd8;
        hz_if.tuse_rs_D = 2'd0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        settle();

        // Reset with a hazard and a mult request present
        load_use();
        hz_if.md_op_E = 2'b01;
        hz_if.md_D    = 1'b1;
        #1;
        check_hz("rst_hz", 1'b0, 1'b1);
        check_md("rst_md", 1'b0, 1'b0, 1'b0);

        settle();
        reset = 1'b0;
        clear_inputs();
        #1;
        check_hz("idle", 1'b0, 1'b0);
        check_md("idle_md", 1'b0, 1'b0, 1'b0);

        // RAW hazards
        settle(); load_use(); #1;
        check_hz("load_use", 1'b1, 1'b1);
        settle(); hz_if.tnew_E = 2'd0; #1;
        check("tnew0", 32'(hz_if.stall), 32'd0);
        settle(); hz_if.tnew_E = 2'd2; hz_if.we_E = 1'b0; #1;
        check("we_e0", 32'(hz_if.stall), 32'd0);
        settle(); clear_inputs();
        hz_if.we_E = 1'b1; hz_if.tnew_E = 2'd2; hz_if.tuse_rs_D = 2'd0; #1;
        check("zero_reg", 32'(hz_if.stall), 32'd0);
        settle(); clear_inputs();
        hz_if.we_M = 1'b1; hz_if.a3_M = 5'd8; hz_if.tnew_M = 2'd1;
        hz_if.rs_D = 5'd8; hz_if.tuse_rs_D = 2'd0; #1;
        check("m_rs", 32'(hz_if.stall), 32'd1);
        settle(); hz_if.tuse_rs_D = 2'd1; #1;
        check("m_rs_eq", 32'(hz_if.stall), 32'd0);
        settle(); clear_inputs();
        hz_if.we_E = 1'b1; hz_if.a3_E = 5'd9; hz_if.tnew_E = 2'd2;
        hz_if.rt_D = 5'd9; hz_if.tuse_rt_D = 2'd1; #1;
        check("e_rt", 32'(hz_if.stall), 32'd1);
        settle(); hz_if.tuse_rt_D = 2'd3; #1;
        check("e_rt_unused", 32'(hz_if.stall), 32'd0);
        settle(); hz_if.md_op_E = 2'b11; #1;
        check("op11", 32'(hz_if.md_start), 32'd0);

        // mult with md_D held: 1 start + 5 busy stalled cycles
        settle(); clear_inputs();
        hz_if.md_op_E = 2'b01; hz_if.md_D = 1'b1; #1;
        check_md("mul_start", 1'b1, 1'b0, 1'b0);
        check_hz("mul_start", 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            settle();
            hz_if.md_op_E = (i == 2) ? 2'b10 : 2'b00;
            if (i == 3) load_use();
            else begin hz_if.we_E = 1'b0; hz_if.rs_D = 5'd0; end
            #1;
            check_md($sformatf("mul_b%0d", i), 1'b0, 1'b1, i == 5);
            check_hz($sformatf("mul_b%0d", i), 1'b1, 1'b1);
        end
        settle(); #1;
        check_md("mul_end", 1'b0, 1'b0, 1'b0);
        check_hz("mul_end", 1'b0, 1'b0);

        // div aborted by reset on its 4th busy cycle
        settle(); hz_if.md_op_E = 2'b10; #1;
        check("div_start", 32'(hz_if.md_start), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            settle(); hz_if.md_op_E = 2'b00; #1;
            check_md($sformatf("div_b%0d", i), 1'b0, 1'b1, 1'b0);
        end
        settle(); reset = 1'b1; load_use(); #1;
        check_hz("div_rst", 1'b0, 1'b1);
        settle(); reset = 1'b0; clear_inputs(); hz_if.md_op_E = 2'b01; #1;
        check_md("div_abort", 1'b1, 1'b0, 1'b0);
        settle(); hz_if.md_op_E = 2'b00;
        for (int i = 0; i < 6; i++) settle();
        #1;
        check_md("post_mul", 1'b0, 1'b0, 1'b0);

`ifdef HAZARD_PERF_EN
        settle(); reset = 1'b1;
        settle(); reset = 1'b0; #1;
        check("perf_rst", stall_cnt, 32'd0);
        load_use();
        for (int i = 0; i < 7; i++) settle();
        clear_inputs(); #1;
        check("perf_7", stall_cnt, 32'd7);
        settle();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        load_use();
        for (int i = 0; i < 3; i++) settle();
        clear_inputs(); #1;
        check("perf_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
